// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x4 keypad column scanner.
// Latency: n/a (declarations only). Backpressure: n/a.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN_DRIVE,
        SCAN_SAMPLE,
        LOCK
    } scan_state_t;

    // Indexed [row][col]; row 3 is the bottom row of the physical pad.
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [3:0] col_drive_n(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and key-event signals of the scanner, grouped for port connection.
// Latency: n/a (wiring only). Backpressure: none; key_new is a fire-and-forget pulse.
interface keypad_scanner_if;
    logic [3:0] rows;
    logic [3:0] cols;
    logic       key_pressed;
    logic [3:0] key_code;
    logic       key_new;

    modport master (
        input  rows,
        output cols,
        output key_pressed,
        output key_code,
        output key_new
    );

    modport slave (
        output rows,
        input  cols,
        input  key_pressed,
        input  key_code,
        input  key_new
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, resets to all-ones.
// Latency: 2 cycles. Backpressure: none.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scan controller for a 4x4 keypad; locks on the first key found until released.
// Latency: rows are seen 2 cycles late; a column is sampled SETTLE_CYCLES after it is driven.
// Backpressure: none. Optional KEYPAD_GHOST_REJECT_EN treats multi-row hits as no key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int RELEASE_CYCLES = 2000
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.master  kp
);

    localparam int CNT_MAX = max2(SETTLE_CYCLES, RELEASE_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT      = CW'(CNT_MAX);

    scan_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [1:0]    col_q,   col_d;
    logic [1:0]    row_q,   row_d;
    logic [3:0]    code_q,  code_d;
    logic          new_q,   new_d;

    logic [3:0]    rows_s;
    logic          row_hit;
    logic [1:0]    row_sel;
    logic          key_ok;
    logic [CW-1:0] cnt_inc;

    sync_2ff #(.WIDTH(4)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (kp.rows),
        .q_o   (rows_s)
    );

    // Descending loop so the lowest-index low row is the one left selected.
    always_comb begin
        row_hit = 1'b0;
        row_sel = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!rows_s[r]) begin
                row_hit = 1'b1;
                row_sel = r[1:0];
            end
        end
    end

`ifdef KEYPAD_GHOST_REJECT_EN
    logic [2:0] rows_low;

    always_comb begin
        rows_low = 3'd0;
        for (int r = 0; r < 4; r++) begin
            if (!rows_s[r]) begin
                rows_low = rows_low + 3'd1;
            end
        end
    end

    assign key_ok = row_hit && (rows_low == 3'd1);
`else
    assign key_ok = row_hit;
`endif

    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        row_d   = row_q;
        code_d  = code_q;
        new_d   = 1'b0;

        unique case (state_q)
            SCAN_DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SCAN_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            SCAN_SAMPLE: begin
                cnt_d = '0;
                if (key_ok) begin
                    state_d = LOCK;
                    row_d   = row_sel;
                    code_d  = KEY_MAP[row_sel][col_q];
                    new_d   = 1'b1;
                end else begin
                    state_d = SCAN_DRIVE;
                    col_d   = col_q + 2'd1;
                end
            end

            LOCK: begin
                if (!rows_s[row_q]) begin
                    cnt_d = '0;
                end else if (cnt_q == RELEASE_LAST) begin
                    // Release resumes on the next column rather than re-finding the same key.
                    state_d = SCAN_DRIVE;
                    cnt_d   = '0;
                    col_d   = col_q + 2'd1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = SCAN_DRIVE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= SCAN_DRIVE;
            cnt_q   <= '0;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            code_q  <= 4'h0;
            new_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            row_q   <= row_d;
            code_q  <= code_d;
            new_q   <= new_d;
        end
    end

    assign kp.cols        = col_drive_n(col_q);
    assign kp.key_pressed = (state_q == LOCK);
    assign kp.key_code    = code_q;
    assign kp.key_new     = new_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SETTLE_CYCLES=4, RELEASE_CYCLES=8 and a row/col short keypad model.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pressed;
    logic        bounce;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          new_cnt  = 0;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SETTLE_CYCLES  (4),
        .RELEASE_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    always #5 clk = ~clk;

    // Key at (r,c) pulls row r low while column c is driven low; bounce forces all rows open.
    always_comb begin
        kp.rows = 4'hF;
        if (!bounce) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    if (pressed[r*4+c] && (kp.cols[c] == 1'b0)) begin
                        kp.rows[r] = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (kp.key_new === 1'b1) new_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_cols;

        reset   = 1'b0;
        pressed = 16'h0000;
        bounce  = 1'b0;

        // 1: reset state
        tick();
        tick();
        chk("rst_cols",    kp.cols,        4'b1110);
        chk("rst_pressed", kp.key_pressed, 1'b0);
        chk("rst_code",    kp.key_code,    4'h0);
        chk("rst_new",     kp.key_new,     1'b0);

        // 2: idle sweep, each column held 5 cycles
        reset = 1'b1;
        for (int n = 0; n <= 20; n++) begin
            exp_cols = ~(4'b0001 << ((n / 5) % 4));
            chk("scan_cols", kp.cols, exp_cols);
            if (n < 20) tick();
        end
        chk("scan_no_new", new_cnt, 0);

        // 3: press '5' at the start of a column-0 period; lock lands 10 cycles later
        pressed[1*4+1] = 1'b1;
        repeat (9) tick();
        chk("k5_not_yet",  kp.key_pressed, 1'b0);
        tick();
        chk("k5_new",      kp.key_new,     1'b1);
        chk("k5_pressed",  kp.key_pressed, 1'b1);
        chk("k5_code",     kp.key_code,    4'h5);
        chk("k5_cols",     kp.cols,        4'b1101);
        tick();
        chk("k5_new_once", kp.key_new,     1'b0);
        repeat (5) tick();
        chk("k5_hold_cols", kp.cols,       4'b1101);
        chk("k5_hold_kp",   kp.key_pressed, 1'b1);
        chk("k5_new_cnt",   new_cnt,       1);

        // 4: 3-cycle bounce keeps the lock; real release takes 2 sync + 8 high cycles
        bounce = 1'b1;
        repeat (3) tick();
        bounce = 1'b0;
        repeat (12) tick();
        chk("bounce_hold", kp.key_pressed, 1'b1);
        pressed = 16'h0000;
        repeat (9) tick();
        chk("rel_not_yet", kp.key_pressed, 1'b1);
        tick();
        chk("rel_pressed", kp.key_pressed, 1'b0);
        chk("rel_cols",    kp.cols,        4'b1011);
        chk("rel_code",    kp.key_code,    4'h5);
        chk("rel_new_cnt", new_cnt,        1);

        // 5: '3' and '9' together in column 2
        pressed[0*4+2] = 1'b1;
        pressed[2*4+2] = 1'b1;
        repeat (5) tick();
`ifdef KEYPAD_GHOST_REJECT_EN
        chk("ghost_no_lock", kp.key_pressed, 1'b0);
        chk("ghost_cols",    kp.cols,        4'b0111);
        chk("ghost_code",    kp.key_code,    4'h5);
        chk("ghost_new_cnt", new_cnt,        1);
        pressed = 16'h0000;
`else
        chk("multi_pressed", kp.key_pressed, 1'b1);
        chk("multi_new",     kp.key_new,     1'b1);
        chk("multi_code",    kp.key_code,    4'h3);
        chk("multi_cols",    kp.cols,        4'b1011);
        pressed = 16'h0000;
        repeat (10) tick();
        chk("multi_rel",      kp.key_pressed, 1'b0);
        chk("multi_rel_cols", kp.cols,        4'b0111);
`endif

        // 6: lock on 'D' then reset mid-lock
        pressed[3*4+3] = 1'b1;
        repeat (5) tick();
        chk("kd_code",    kp.key_code,    4'hD);
        chk("kd_pressed", kp.key_pressed, 1'b1);
        chk("kd_cols",    kp.cols,        4'b0111);
        chk("kd_new",     kp.key_new,     1'b1);
        reset = 1'b0;
        tick();
        chk("lrst_cols",    kp.cols,        4'b1110);
        chk("lrst_pressed", kp.key_pressed, 1'b0);
        chk("lrst_code",    kp.key_code,    4'h0);
        chk("lrst_new",     kp.key_new,     1'b0);
        reset = 1'b1;
        tick();
        chk("restart_cols", kp.cols,        4'b1110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
